main_bus_arbiter: RTL and testbench

- Shares the single main memory bus (bus_req/bus_reqcyc/bus_reqtag/bus_respack drivers) among the cache fill engines (addr_to_data) and flush engines (store_data).
- Each engine raises abtr_reqcyc, waits for abtr_grant, then signals bus_busy for the duration of its transaction.
- The arbiter grants one owner at a time, round-robin, inserts a one-cycle dead turnaround between owners, revokes grants that are never used, and flags protocol errors.

---
 rtl/main_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_main_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter for the shared main memory bus between the cache fill and flush engines.
// Grants one owner at a time, inserts a dead turnaround cycle, revokes unused grants, flags busy collisions.
module main_bus_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned OWNER_W       = 2,
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] abtr_reqcyc,
    input  logic [NUM_REQ-1:0] bus_busy,
    output logic [NUM_REQ-1:0] abtr_grant,
    output logic [OWNER_W-1:0] owner,
    output logic               bus_owned,
    output logic               timeout_err,
    output logic               collision_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_BUSY,
        ST_TURN
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] rr_last_q, rr_last_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               bus_owned_q, bus_owned_d;
    logic               timeout_err_q, timeout_err_d;
    logic               collision_err_q, collision_err_d;

    logic [OWNER_W-1:0] arb_ptr;
    logic [OWNER_W-1:0] cand;
    logic [OWNER_W-1:0] win_idx;
    logic               win_valid;
    logic [NUM_REQ-1:0] busy_ignore;

    // In TURN the pointer is already the departing owner, so it drops to lowest priority at once
    always_comb begin
        arb_ptr   = (state_q == ST_TURN) ? owner_q : rr_last_q;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = OWNER_W'((32'(arb_ptr) + i) % NUM_REQ);
            if (!win_valid && abtr_reqcyc[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Owner's busy is legal while granted and may lag one cycle into TURN
    always_comb begin
        busy_ignore = '0;
        if (state_q != ST_IDLE) begin
            busy_ignore = NUM_REQ'(1) << owner_q;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        owner_d         = owner_q;
        rr_last_d       = rr_last_q;
        wait_cnt_d      = wait_cnt_q;
        timeout_err_d   = 1'b0;
        collision_err_d = collision_err_q | (|(bus_busy & ~busy_ignore));

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d    = NUM_REQ'(1) << win_idx;
                    owner_d    = win_idx;
                    wait_cnt_d = '0;
                    state_d    = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (bus_busy[owner_q]) begin
                    state_d = ST_BUSY;
                end else if (!abtr_reqcyc[owner_q]) begin
                    grant_d = '0;
                    state_d = ST_TURN;
                end else if (wait_cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    grant_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_TURN;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (!bus_busy[owner_q]) begin
                    grant_d = '0;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                rr_last_d = owner_q;
                if (win_valid) begin
                    grant_d    = NUM_REQ'(1) << win_idx;
                    owner_d    = win_idx;
                    wait_cnt_d = '0;
                    state_d    = ST_GRANTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        bus_owned_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            owner_q         <= '0;
            rr_last_q       <= OWNER_W'(NUM_REQ - 1);
            wait_cnt_q      <= '0;
            bus_owned_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
            collision_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            owner_q         <= owner_d;
            rr_last_q       <= rr_last_d;
            wait_cnt_q      <= wait_cnt_d;
            bus_owned_q     <= bus_owned_d;
            timeout_err_q   <= timeout_err_d;
            collision_err_q <= collision_err_d;
        end
    end

    assign abtr_grant    = grant_q;
    assign owner         = owner_q;
    assign bus_owned     = bus_owned_q;
    assign timeout_err   = timeout_err_q;
    assign collision_err = collision_err_q;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter: reset, single request, round-robin order, fairness,
// withdrawal, timeout, collision and reset during a transaction.
module tb_main_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] abtr_reqcyc;
    logic [3:0] bus_busy;
    logic [3:0] abtr_grant;
    logic [1:0] owner;
    logic       bus_owned;
    logic       timeout_err;
    logic       collision_err;

    int n_checks;
    int n_errors;

    main_bus_arbiter #(
        .NUM_REQ      (4),
        .OWNER_W      (2),
        .GRANT_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .abtr_reqcyc  (abtr_reqcyc),
        .bus_busy     (bus_busy),
        .abtr_grant   (abtr_grant),
        .owner        (owner),
        .bus_owned    (bus_owned),
        .timeout_err  (timeout_err),
        .collision_err(collision_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge and grant must stay onehot0
    task automatic step();
        @(posedge clk);
        #1;
        chk("grant_onehot0", 32'($onehot0(abtr_grant)), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] o);
        chk({tag, "_grant"}, 32'(abtr_grant), 32'(g));
        chk({tag, "_owned"}, 32'(bus_owned), 32'(|g));
        if (|g) chk({tag, "_owner"}, 32'(owner), 32'(o));
    endtask

    initial begin
        logic [1:0] order [5];
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        abtr_reqcyc = '0;
        bus_busy    = '0;
        step();
        step();

        // Reset state
        chk("rst_grant", 32'(abtr_grant), 32'd0);
        chk("rst_owned", 32'(bus_owned), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_coll", 32'(collision_err), 32'd0);
        reset = 1'b0;
        step();

        // Single request from requester 2
        abtr_reqcyc = 4'b0100;
        step();
        chk_grant("single", 4'b0100, 2'd2);
        bus_busy = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_grant("single_busy", 4'b0100, 2'd2);
        end
        bus_busy    = '0;
        abtr_reqcyc = '0;
        step();
        chk_grant("single_turn", 4'b0000, 2'd0);
        step();
        chk_grant("single_idle", 4'b0000, 2'd0);
        chk("single_coll", 32'(collision_err), 32'd0);

        // All four request after reset: strict order 0,1,2,3,0 with a dead cycle between
        do_reset();
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        abtr_reqcyc = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_grant("rr", 4'b0001 << order[k], order[k]);
            bus_busy = 4'b0001 << order[k];
            step();
            step();
            step();
            chk_grant("rr_busy", 4'b0001 << order[k], order[k]);
            bus_busy = '0;
            step();
            chk_grant("rr_turn", 4'b0000, 2'd0);
        end
        abtr_reqcyc = '0;
        step();
        chk_grant("rr_idle", 4'b0000, 2'd0);

        // Requesters 0 and 3 contend continuously: grants alternate
        do_reset();
        order = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
        abtr_reqcyc = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_grant("fair", 4'b0001 << order[k], order[k]);
            bus_busy = 4'b0001 << order[k];
            step();
            bus_busy = '0;
            step();
            chk_grant("fair_turn", 4'b0000, 2'd0);
        end
        abtr_reqcyc = '0;
        step();

        // Withdrawal: requester 1 granted, drops request after three cycles
        abtr_reqcyc = 4'b0010;
        step();
        chk_grant("wd", 4'b0010, 2'd1);
        step();
        step();
        abtr_reqcyc = '0;
        step();
        chk_grant("wd_turn", 4'b0000, 2'd0);
        chk("wd_tmo", 32'(timeout_err), 32'd0);
        step();
        chk("wd_tmo_idle", 32'(timeout_err), 32'd0);

        // Timeout: requester 3 never raises busy; 0 is waiting behind it
        abtr_reqcyc = 4'b1001;
        step();
        chk_grant("tmo_grant", 4'b1000, 2'd3);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("tmo_wait_err", 32'(timeout_err), 32'd0);
            chk("tmo_wait_grant", 32'(abtr_grant), 32'h8);
        end
        step();
        chk("tmo_pulse", 32'(timeout_err), 32'd1);
        chk_grant("tmo_turn", 4'b0000, 2'd0);
        step();
        chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
        chk_grant("tmo_next", 4'b0001, 2'd0);

        // Collision: requester 2 drives busy while 0 owns the bus
        bus_busy = 4'b0001;
        step();
        chk("coll_pre", 32'(collision_err), 32'd0);
        bus_busy = 4'b0101;
        step();
        chk("coll_set", 32'(collision_err), 32'd1);
        chk_grant("coll_owner", 4'b0001, 2'd0);
        bus_busy = 4'b0001;
        step();
        chk("coll_sticky", 32'(collision_err), 32'd1);
        chk_grant("coll_owner2", 4'b0001, 2'd0);
        bus_busy = '0;
        step();
        chk_grant("coll_turn", 4'b0000, 2'd0);
        chk("coll_sticky2", 32'(collision_err), 32'd1);

        // Reset while requester 3 is mid-transaction
        step();
        chk_grant("rmid_grant", 4'b1000, 2'd3);
        bus_busy = 4'b1000;
        step();
        step();
        chk_grant("rmid_busy", 4'b1000, 2'd3);
        reset = 1'b1;
        step();
        chk_grant("rmid_rst", 4'b0000, 2'd0);
        chk("rmid_coll", 32'(collision_err), 32'd0);
        chk("rmid_tmo", 32'(timeout_err), 32'd0);
        reset       = 1'b0;
        bus_busy    = '0;
        abtr_reqcyc = 4'b1001;
        step();
        chk_grant("rmid_first", 4'b0001, 2'd0);
        chk("rmid_coll2", 32'(collision_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
